approx_mul_pipe: RTL

//  Parametrised, pipelined successor of the 8x8 quadrant approximate multiplier: splits
//  W-bit operands into halves, forms four H x H partial products, each exact or truncated
//  per a run-time mode, and sums them. Sits between operand producers and accumulate

---
 rtl/approx_mul_pkg.sv | 15 +
 rtl/approx_pp.sv | 32 +++
 rtl/approx_mul_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared mode encodings and the truncation-mask helper for the approximate multiplier.
// Partial products are at most 32 bits wide, which bounds the supported operand width.
package approx_mul_pkg;

    localparam logic [1:0] MODE_EXACT       = 2'd0;
    localparam logic [1:0] MODE_LOW_APPROX  = 2'd1;
    localparam logic [1:0] MODE_FULL_APPROX = 2'd2;
    localparam logic [1:0] MODE_DROP_LL     = 2'd3;

    // Ones everywhere except the low `trunc` bits.
    function automatic logic [31:0] approx_mask(input int unsigned trunc);
        approx_mask = ~((32'd1 << trunc) - 32'd1);
    endfunction

endpackage

// File: rtl/approx_pp.sv
// One H x H partial product, optionally truncated or forced to zero.
// Purely combinational; zero_en overrides approx_en.
module approx_pp
    import approx_mul_pkg::*;
#(
    parameter int unsigned H     = 4,
    parameter int unsigned TRUNC = 2
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    input  logic           approx_en,
    input  logic           zero_en,
    output logic [2*H-1:0] p
);

    localparam logic [31:0]    MASK32 = approx_mask(TRUNC);
    localparam logic [2*H-1:0] MASK   = MASK32[2*H-1:0];

    logic [2*H-1:0] prod;

    assign prod = {{H{1'b0}}, x} * {{H{1'b0}}, y};

    always_comb begin
        p = prod;
        if (zero_en) begin
            p = '0;
        end else if (approx_en) begin
            p = prod & MASK;
        end
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined quadrant multiplier with per-beat approximation mode,
// global-stall valid/ready flow control and a saturating approximate-result counter.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned TRUNC = 2,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
    output logic [1:0]       out_mode,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] approx_cnt
);

    localparam int unsigned H = W / 2;

    logic             en;
    logic             out_fire;

    logic             v1_q;
    logic [W-1:0]     a1_q;
    logic [W-1:0]     b1_q;
    logic [1:0]       mode1_q;
    logic [TAG_W-1:0] tag1_q;

    logic             v2_q;
    logic [W-1:0]     ll_q, lh_q, hl_q, hh_q;
    logic [1:0]       mode2_q;
    logic [TAG_W-1:0] tag2_q;

    logic [W-1:0]     ll_d, lh_d, hl_d, hh_d;
    logic             lo_approx, all_approx, drop_ll;
    logic [2*W-1:0]   sum_d;
    logic [CNT_W-1:0] cnt_d;

    // Whole pipe advances together; bubbles ride along rather than being squeezed out.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign out_fire = out_valid && out_ready;

    assign lo_approx  = (mode1_q == MODE_LOW_APPROX) || (mode1_q == MODE_FULL_APPROX);
    assign all_approx = (mode1_q == MODE_FULL_APPROX);
    assign drop_ll    = (mode1_q == MODE_DROP_LL);

    approx_pp #(.H(H), .TRUNC(TRUNC)) u_pp_ll (
        .x(a1_q[H-1:0]), .y(b1_q[H-1:0]), .approx_en(lo_approx), .zero_en(drop_ll), .p(ll_d)
    );
    approx_pp #(.H(H), .TRUNC(TRUNC)) u_pp_lh (
        .x(a1_q[H-1:0]), .y(b1_q[W-1:H]), .approx_en(lo_approx), .zero_en(1'b0), .p(lh_d)
    );
    approx_pp #(.H(H), .TRUNC(TRUNC)) u_pp_hl (
        .x(a1_q[W-1:H]), .y(b1_q[H-1:0]), .approx_en(all_approx), .zero_en(1'b0), .p(hl_d)
    );
    approx_pp #(.H(H), .TRUNC(TRUNC)) u_pp_hh (
        .x(a1_q[W-1:H]), .y(b1_q[W-1:H]), .approx_en(all_approx), .zero_en(1'b0), .p(hh_d)
    );

    always_comb begin
        sum_d = {hh_q, {W{1'b0}}}
              + (({{W{1'b0}}, lh_q} + {{W{1'b0}}, hl_q}) << H)
              + {{W{1'b0}}, ll_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            a1_q      <= '0;
            b1_q      <= '0;
            mode1_q   <= '0;
            tag1_q    <= '0;
            v2_q      <= 1'b0;
            ll_q      <= '0;
            lh_q      <= '0;
            hl_q      <= '0;
            hh_q      <= '0;
            mode2_q   <= '0;
            tag2_q    <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_mode  <= '0;
            out_tag   <= '0;
        end else if (en) begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            if (in_valid) begin
                a1_q    <= in_a;
                b1_q    <= in_b;
                mode1_q <= in_mode;
                tag1_q  <= in_tag;
            end
            if (v1_q) begin
                ll_q    <= ll_d;
                lh_q    <= lh_d;
                hl_q    <= hl_d;
                hh_q    <= hh_d;
                mode2_q <= mode1_q;
                tag2_q  <= tag1_q;
            end
            if (v2_q) begin
                out_prod <= sum_d;
                out_mode <= mode2_q;
                out_tag  <= tag2_q;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = approx_cnt;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && (out_mode != MODE_EXACT) && (approx_cnt != {CNT_W{1'b1}})) begin
            cnt_d = approx_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= '0;
        end else begin
            approx_cnt <= cnt_d;
        end
    end

endmodule
